nn_layer_engine: RTL



---
 rtl/nn_layer_engine.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/nn_layer_engine.sv
// rtl/nn_layer_engine.sv - LANES-wide dense-layer MAC engine: buffers one input vector, streams neuron results.
// Optional feature: define NN_RELU_EN to clamp negative results to zero on the output stream.
module nn_layer_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int MAX_LEN    = 256,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_W-1:0]            vector_len,
  input  logic [LEN_W-1:0]            neuron_count,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  input  logic                        wt_valid,
  input  logic [LANES*DATA_WIDTH-1:0] wt_data,
  output logic                        wt_ready,
  output logic                        out_valid,
  output logic [ACC_WIDTH-1:0]        out_data,
  output logic                        out_last,
  input  logic                        out_ready
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  state_t state, state_next;

  logic [LEN_W-1:0]              vlen, idx, remaining, nv;
  logic [LANE_W-1:0]             lane;
  logic signed [DATA_WIDTH-1:0]  vbuf [MAX_LEN];
  logic signed [DATA_WIDTH-1:0]  buf_rd;
  logic signed [ACC_WIDTH-1:0]   acc [LANES];
  logic signed [ACC_WIDTH-1:0]   acc_sel;
  logic signed [2*DATA_WIDTH-1:0] prod [LANES];
  logic cfg_bad, in_hs, wt_hs, out_hs, idx_last, lane_last, more_groups;

  assign cfg_bad     = (vector_len == '0) || (neuron_count == '0) || (vector_len > LEN_W'(MAX_LEN));
  assign in_hs       = in_valid && in_ready;
  assign wt_hs       = wt_valid && wt_ready;
  assign out_hs      = out_valid && out_ready;
  assign idx_last    = (idx == vlen - LEN_W'(1));
  // remaining counts neurons not yet drained, including the current group
  assign nv          = (remaining < LEN_W'(LANES)) ? remaining : LEN_W'(LANES);
  assign lane_last   = (LEN_W'(lane) == nv - LEN_W'(1));
  assign more_groups = (remaining > LEN_W'(LANES));
  assign buf_rd      = vbuf[idx[ADDR_W-1:0]];
  assign acc_sel     = acc[lane];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      prod[l] = (2*DATA_WIDTH)'(buf_rd) *
                (2*DATA_WIDTH)'($signed(wt_data[l*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    in_ready   = (state == LOAD);
    wt_ready   = (state == COMPUTE);
    case (state)
      IDLE:    if (start && !cfg_bad) state_next = LOAD;
      LOAD:    if (in_hs && idx_last) state_next = COMPUTE;
      COMPUTE: if (wt_hs && idx_last) state_next = DRAIN;
      DRAIN:   if (out_hs && lane_last) state_next = more_groups ? COMPUTE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_hs) vbuf[idx[ADDR_W-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      vlen      <= '0;
      idx       <= '0;
      remaining <= '0;
      lane      <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
            end else begin
              cfg_err   <= 1'b0;
              vlen      <= vector_len;
              remaining <= neuron_count;
            end
          end
        end
        LOAD: begin
          if (in_hs) begin
            idx <= idx_last ? '0 : idx + LEN_W'(1);
            if (idx_last) for (int l = 0; l < LANES; l++) acc[l] <= '0;
          end
        end
        COMPUTE: begin
          lane <= '0;
          if (wt_hs) begin
            idx <= idx_last ? '0 : idx + LEN_W'(1);
            for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC_WIDTH'(prod[l]);
          end
        end
        DRAIN: begin
          // one bubble cycle between beats keeps the output register simple
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_last  <= lane_last && !more_groups;
`ifdef NN_RELU_EN
            out_data  <= acc_sel[ACC_WIDTH-1] ? '0 : acc_sel;
`else
            out_data  <= acc_sel;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (lane_last) begin
              if (more_groups) begin
                remaining <= remaining - LEN_W'(LANES);
                for (int l = 0; l < LANES; l++) acc[l] <= '0;
              end else begin
                done <= 1'b1;
              end
            end else begin
              lane <= lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
